// File: rtl/pc_pkg.sv
// Shared definitions for the next-PC unit: jump modes and address-layout constants.
package pc_pkg;

  // Jump modes presented by the control unit; 6 and 7 are unused and decode as SEQ.
  typedef enum logic [2:0] {
    JM_SEQ  = 3'd0,
    JM_J    = 3'd1,
    JM_JR   = 3'd2,
    JM_JAL  = 3'd3,
    JM_BR   = 3'd4,
    JM_JALR = 3'd5
  } jump_mode_e;

  // Pseudo-direct J/JAL targets replace everything below this bit.
  localparam int JTARGET_LSB = 28;

  // Instruction size in bytes; PCs advance and stay aligned to this.
  localparam int PC_ALIGN = 4;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: circular buffer that overwrites its oldest entry when full.
module ras_stack #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             valid,
  output logic             empty
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [WIDTH-1:0] mem_d [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_inc;

  assign ptr_inc = ptr_q + 1'b1;
  assign valid   = (cnt_q != '0);
  assign empty   = (cnt_q == '0);
  assign top     = valid ? mem_q[ptr_q] : '0;

  // Next stack state: push wins over pop; popping an empty stack leaves it untouched.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    mem_d = mem_q;
    if (push) begin
      ptr_d          = ptr_inc;
      mem_d[ptr_inc] = push_data;
      if (cnt_q != CNT_W'(RAS_DEPTH)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (pop && valid) begin
      ptr_d = ptr_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Stack registers, fully cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/pc_next_unit.sv
// Program-counter register with next-PC selection, return-address prediction
// and a saturating misprediction counter.
module pc_next_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter int               RAS_DEPTH = 4,
  parameter int               CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic [2:0]       jump,
  input  logic [27:0]      fjump,
  input  logic [15:0]      br_imm,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] jumpreg,
  input  logic             is_ret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] newdir,
  output logic [WIDTH-1:0] link_addr,
  output logic [WIDTH-1:0] ras_pred,
  output logic             ras_valid,
  output logic             mispredict,
  output logic [CNT_W-1:0] mispred_cnt
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             mispredict_q, mispredict_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic [WIDTH-1:0] j_target;
  logic [WIDTH-1:0] br_offset;
  logic [WIDTH-1:0] br_target;
  logic             ras_push;
  logic             ras_pop;
  logic             ras_empty;

  assign pc_plus4  = pc_q + WIDTH'(PC_ALIGN);
  assign link_addr = pc_plus4;
  assign j_target  = {pc_plus4[WIDTH-1:JTARGET_LSB], fjump};
  // Word offset: sign-extend the 16-bit immediate and scale by 4.
  assign br_offset = {{(WIDTH - 18){br_imm[15]}}, br_imm, 2'b00};
  assign br_target = pc_plus4 + br_offset;

  // Side effects only happen on a non-stalled cycle; JALR with is_ret is a pure push.
  assign ras_push = !stall && ((jump == JM_JAL) || (jump == JM_JALR));
  assign ras_pop  = !stall && (jump == JM_JR) && is_ret;

  ras_stack #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (link_addr),
    .top       (ras_pred),
    .valid     (ras_valid),
    .empty     (ras_empty)
  );

  // Next-PC select; the register target is authoritative regardless of prediction.
  always_comb begin
    newdir = pc_plus4;
    case (jump)
      JM_J, JM_JAL:   newdir = j_target;
      JM_JR, JM_JALR: newdir = jumpreg;
      JM_BR:          newdir = br_taken ? br_target : pc_plus4;
      default:        newdir = pc_plus4;
    endcase
  end

  // Next state of PC, mispredict pulse and saturating counter.
  always_comb begin
    pc_d          = stall ? pc_q : newdir;
    mispredict_d  = ras_pop && (ras_empty || (ras_pred != jumpreg));
    mispred_cnt_d = mispred_cnt_q;
    if (mispredict_d && (mispred_cnt_q != '1)) begin
      mispred_cnt_d = mispred_cnt_q + 1'b1;
    end
  end

  // PC and prediction-status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      mispredict_q  <= 1'b0;
      mispred_cnt_q <= '0;
    end else begin
      pc_q          <= pc_d;
      mispredict_q  <= mispredict_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign pc          = pc_q;
  assign mispredict  = mispredict_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule
